mac_accumulator: RTL and testbench
==================================

// Module: mac_accumulator
// PURPOSE
//   Downstream consumer of the 16x16 signed Booth/Wallace multiplier. Accepts a run of
//   LEN signed 32-bit products over a valid/ready handshake and sums them in a 40-bit
//   guarded accumulator. Emits one saturated 32-bit dot-product result per run, with a
//   saturation flag, and holds it until the result is taken.
// PARAMETERS
//   PROD_W  32  product width (multiplier output width)
//   ACC_W   40  accumulator width (8 guard bits)
//   CNT_W    8  width of run length / product counter
// PORTS
//   clk        in   1       clock; all state updates on rising edge
//   rst        in   1       synchronous, active-high reset
//   start      in   1       begin a run; sampled only in IDLE
//   len        in   CNT_W   number of products in run; latched when start is accepted
//   prod_valid in   1       prod is valid this cycle
//   prod_ready out  1       block accepts prod this cycle
//   prod       in   PROD_W  signed product from multiplier
//   out_valid  out  1       acc_out/sat are valid
//   out_ready  in   1       consumer takes result this cycle
//   acc_out    out  PROD_W  signed saturated run sum
//   sat        out  1       1 = acc_out was clamped
//   busy       out  1       state != IDLE
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE; acc=0, cnt=0, len_q=0; acc_out=0, sat=0,
//     out_valid=0. prod_ready=0 and busy=0 follow combinationally from IDLE. Reset wins
//     over every other input. A reset mid-run discards the partial sum; no result is emitted.
//   FSM states: IDLE, ACCUM, DONE.
//     IDLE : start=1 -> latch len_q=len, acc=0, cnt=0.
//              len!=0 -> ACCUM.
//              len==0 -> DONE, with acc_out=0 and sat=0.
//            start=0 -> stay in IDLE.
//     ACCUM: prod_ready=1. Each edge with prod_valid=1: acc += sign_extend(prod) to ACC_W;
//            cnt += 1. The accept that makes cnt==len_q also loads acc_out/sat from the
//            updated sum and moves to DONE. prod_valid=0 gaps: hold all state.
//     DONE : out_valid=1, prod_ready=0. acc_out/sat hold stable until out_ready=1 at an
//            edge, which moves to IDLE and clears out_valid. start is ignored outside IDLE.
//   Handshake: a transfer occurs only when valid and ready are both 1 at an edge.
//     prod_ready and out_valid are decoded from the state register only; they have no
//     combinational path from inputs.
//   Latency: out_valid rises in the cycle after the edge that accepts the last product.
//     The minimum run of LEN products takes LEN+1 cycles from start to out_valid.
//   Arithmetic: two's complement throughout.
//     With CNT_W=8, |sum| <= 255*2^31 < 2^39, so the 40-bit accumulator never wraps.
//     Saturation on output:
//       sum >  2^31-1 -> acc_out=32'h7FFF_FFFF, sat=1
//       sum < -2^31   -> acc_out=32'h8000_0000, sat=1
//       otherwise     -> acc_out=sum[31:0],     sat=0
//     Intermediate sums may exceed 32 bits; only the final sum is clamped.
//   Simultaneous events: in DONE, out_ready=1 with start=1 in the same cycle -> go to IDLE
//     only; that start is not accepted. A new start is sampled on a later edge.
// TESTING
//   1. start, len=3; prods 100, -250, 7 with one idle cycle between them
//      -> acc_out=32'hFFFF_FF71 (-143), sat=0, out_valid 1 cycle after the 3rd accept.
//   2. len=2; prods 32'h7FFF_FFFF, 32'h7FFF_FFFF
//      -> acc_out=32'h7FFF_FFFF, sat=1.
//      Also len=2; prods 32'h8000_0000 x2 -> acc_out=32'h8000_0000, sat=1.
//   3. len=3; prods 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0002 (intermediate >2^31)
//      -> acc_out=32'h7FFF_FFFF? No: sum=2^31-1+2^31-1-2^31+2=2^31 -> clamp
//      32'h7FFF_FFFF, sat=1.
//      Variant with last prod 32'h8000_0001 -> sum=2^31-1 -> acc_out=32'h7FFF_FFFF, sat=0.
//   4. len=0 -> out_valid=1 in the cycle after start, acc_out=0, sat=0; prod_ready never 1.
//   5. Backpressure: len=1, prod=5, then out_ready=0 for 5 cycles with start pulsed and
//      prod_valid=1 -> acc_out=5 held, prod_ready=0, busy=1, start ignored. Then
//      out_ready=1 -> IDLE on the next edge.
//   6. rst=1 after 1 of 3 products accepted -> next cycle IDLE, out_valid=0, acc_out=0.
//      New run len=1, prod=-9 -> acc_out=32'hFFFF_FFF7, sat=0.

Source files
------------

// File: rtl/mac_accumulator_if.sv
// Handshake bundle between the multiplier-side producer, the MAC accumulator and
// the result consumer. The master drives run control, products and result accept.
// The slave (the accumulator) drives ready, result and status.
interface mac_accumulator_if #(
  parameter int PROD_W = 32,
  parameter int CNT_W  = 8
);
  logic                     start;
  logic [CNT_W-1:0]         len;
  logic                     prod_valid;
  logic                     prod_ready;
  logic signed [PROD_W-1:0] prod;
  logic                     out_valid;
  logic                     out_ready;
  logic [PROD_W-1:0]        acc_out;
  logic                     sat;
  logic                     busy;

  modport master (
    output start, len, prod_valid, prod, out_ready,
    input  prod_ready, out_valid, acc_out, sat, busy
  );

  modport slave (
    input  start, len, prod_valid, prod, out_ready,
    output prod_ready, out_valid, acc_out, sat, busy
  );
endinterface

// File: rtl/mac_accumulator.sv
// Run-length dot-product accumulator. The block sums LEN signed products in a
// guarded accumulator. It emits one result per run, saturated to PROD_W bits, and
// holds that result until the consumer takes it. Handshake outputs are decoded
// from the state register only, so they have no combinational path from inputs.
module mac_accumulator #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  mac_accumulator_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Clamp limits expressed in accumulator width, plus the matching output codes.
  localparam logic signed [ACC_W-1:0] SUM_MAX =
    {{(ACC_W-PROD_W+1){1'b0}}, {(PROD_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SUM_MIN =
    {{(ACC_W-PROD_W+1){1'b1}}, {(PROD_W-1){1'b0}}};
  localparam logic [PROD_W-1:0] OUT_MAX = {1'b0, {(PROD_W-1){1'b1}}};
  localparam logic [PROD_W-1:0] OUT_MIN = {1'b1, {(PROD_W-1){1'b0}}};

  // Returns {sat, value}: the final sum clamped to the signed PROD_W range.
  function automatic logic [PROD_W:0] saturate(input logic signed [ACC_W-1:0] sum);
    logic [PROD_W:0] res;
    if (sum > SUM_MAX) begin
      res = {1'b1, OUT_MAX};
    end else if (sum < SUM_MIN) begin
      res = {1'b1, OUT_MIN};
    end else begin
      res = {1'b0, sum[PROD_W-1:0]};
    end
    return res;
  endfunction

  state_e                    state_q,   state_d;
  logic signed [ACC_W-1:0]   acc_q,     acc_d;
  logic [CNT_W-1:0]          cnt_q,     cnt_d;
  logic [CNT_W-1:0]          len_q,     len_d;
  logic [PROD_W-1:0]         acc_out_q, acc_out_d;
  logic                      sat_q,     sat_d;

  logic signed [ACC_W-1:0]   prod_ext_s;
  logic signed [ACC_W-1:0]   acc_sum_s;
  logic [CNT_W-1:0]          cnt_inc_s;
  logic                      last_s;
  logic                      prod_ready_s;
  logic                      out_valid_s;
  logic                      busy_s;

  assign prod_ext_s = {{(ACC_W-PROD_W){bus.prod[PROD_W-1]}}, bus.prod};
  assign acc_sum_s  = acc_q + prod_ext_s;
  assign cnt_inc_s  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign last_s     = (cnt_inc_s == len_q);

  // State and datapath registers; reset dominates every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= {ACC_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      len_q     <= {CNT_W{1'b0}};
      acc_out_q <= {PROD_W{1'b0}};
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      acc_out_q <= acc_out_d;
      sat_q     <= sat_d;
    end
  end

  // Next-state logic: start only counts in IDLE, and out_ready drains DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = (bus.len == {CNT_W{1'b0}}) ? ST_DONE : ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (bus.prod_valid && last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath updates: clear on start, accumulate on accept, load result on last accept.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    acc_out_d = acc_out_q;
    sat_d     = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          len_d = bus.len;
          acc_d = {ACC_W{1'b0}};
          cnt_d = {CNT_W{1'b0}};
          if (bus.len == {CNT_W{1'b0}}) begin
            acc_out_d = {PROD_W{1'b0}};
            sat_d     = 1'b0;
          end else begin
            acc_out_d = acc_out_q;
            sat_d     = sat_q;
          end
        end else begin
          len_d = len_q;
        end
      end
      ST_ACCUM: begin
        if (bus.prod_valid) begin
          acc_d = acc_sum_s;
          cnt_d = cnt_inc_s;
          if (last_s) begin
            {sat_d, acc_out_d} = saturate(acc_sum_s);
          end else begin
            acc_out_d = acc_out_q;
          end
        end else begin
          acc_d = acc_q;
        end
      end
      ST_DONE: begin
        acc_d = acc_q;
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  // Output decode from the state register only.
  always_comb begin
    prod_ready_s = 1'b0;
    out_valid_s  = 1'b0;
    busy_s       = 1'b1;
    case (state_q)
      ST_IDLE:  busy_s       = 1'b0;
      ST_ACCUM: prod_ready_s = 1'b1;
      ST_DONE:  out_valid_s  = 1'b1;
      default:  busy_s       = 1'b1;
    endcase
  end

  assign bus.prod_ready = prod_ready_s;
  assign bus.out_valid  = out_valid_s;
  assign bus.busy       = busy_s;
  assign bus.acc_out    = acc_out_q;
  assign bus.sat        = sat_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed self-checking bench for mac_accumulator. Inputs change 1 time unit
// after a rising edge and outputs are sampled at the same point.
module tb_mac_accumulator;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mac_accumulator_if #(.PROD_W(32), .CNT_W(8)) bus ();

  mac_accumulator #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.prod_ready !== 1'b0) begin n_fail++; $display("FAIL reset_prod_ready: got %b expected 0", bus.prod_ready); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.acc_out !== 32'h0000_0000) begin n_fail++; $display("FAIL reset_acc_out: got %h expected 00000000", bus.acc_out); end
    n_checks++; if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b expected 0", bus.sat); end
  endtask

  // len=3, products 100, -250, 7 with an idle cycle between each.
  task automatic test_basic_gaps();
    bus.start = 1'b1; bus.len = 8'd3;
    step();
    bus.start = 1'b0;
    n_checks++; if (bus.prod_ready !== 1'b1) begin n_fail++; $display("FAIL basic_prod_ready: got %b expected 1", bus.prod_ready); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
    bus.prod = 32'd100; bus.prod_valid = 1'b1; step();
    bus.prod_valid = 1'b0; step();
    bus.prod = 32'hFFFF_FF06; bus.prod_valid = 1'b1; step();
    bus.prod_valid = 1'b0; step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", bus.out_valid); end
    bus.prod = 32'd7; bus.prod_valid = 1'b1; step();
    bus.prod_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b expected 1", bus.out_valid); end
    n_checks++; if (bus.acc_out !== 32'hFFFF_FF71) begin n_fail++; $display("FAIL basic_acc_out: got %h expected ffffff71", bus.acc_out); end
    n_checks++; if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL basic_sat: got %b expected 0", bus.sat); end
    n_checks++; if (bus.prod_ready !== 1'b0) begin n_fail++; $display("FAIL basic_done_ready: got %b expected 0", bus.prod_ready); end
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_taken: got %b expected 0", bus.out_valid); end
  endtask

  // Saturation boundaries, products fed back to back.
  task automatic test_saturation();
    logic [31:0] tv_p   [0:4][0:2];
    int          tv_len [0:4];
    logic [31:0] tv_exp [0:4];
    logic        tv_sat [0:4];
    tv_p[0][0] = 32'h7FFF_FFFF; tv_p[0][1] = 32'h7FFF_FFFF; tv_p[0][2] = 32'h0;
    tv_len[0] = 2; tv_exp[0] = 32'h7FFF_FFFF; tv_sat[0] = 1'b1;
    tv_p[1][0] = 32'h8000_0000; tv_p[1][1] = 32'h8000_0000; tv_p[1][2] = 32'h0;
    tv_len[1] = 2; tv_exp[1] = 32'h8000_0000; tv_sat[1] = 1'b1;
    tv_p[2][0] = 32'h7FFF_FFFF; tv_p[2][1] = 32'h7FFF_FFFF; tv_p[2][2] = 32'h8000_0002;
    tv_len[2] = 3; tv_exp[2] = 32'h7FFF_FFFF; tv_sat[2] = 1'b1;
    tv_p[3][0] = 32'h7FFF_FFFF; tv_p[3][1] = 32'h7FFF_FFFF; tv_p[3][2] = 32'h8000_0001;
    tv_len[3] = 3; tv_exp[3] = 32'h7FFF_FFFF; tv_sat[3] = 1'b0;
    tv_p[4][0] = 32'h8000_0000; tv_p[4][1] = 32'h0000_0000; tv_p[4][2] = 32'h0;
    tv_len[4] = 2; tv_exp[4] = 32'h8000_0000; tv_sat[4] = 1'b0;
    for (int v = 0; v < 5; v++) begin
      bus.start = 1'b1; bus.len = 8'(tv_len[v]);
      step();
      bus.start = 1'b0;
      for (int k = 0; k < tv_len[v]; k++) begin
        bus.prod = tv_p[v][k]; bus.prod_valid = 1'b1;
        step();
      end
      bus.prod_valid = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL sat%0d_out_valid: got %b expected 1", v, bus.out_valid); end
      n_checks++; if (bus.acc_out !== tv_exp[v]) begin n_fail++; $display("FAIL sat%0d_acc_out: got %h expected %h", v, bus.acc_out, tv_exp[v]); end
      n_checks++; if (bus.sat !== tv_sat[v]) begin n_fail++; $display("FAIL sat%0d_flag: got %b expected %b", v, bus.sat, tv_sat[v]); end
      bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    end
  endtask

  // len=0 produces a zero result in the cycle after start, never asking for products.
  task automatic test_len_zero();
    bus.start = 1'b1; bus.len = 8'd0;
    step();
    bus.start = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL len0_out_valid: got %b expected 1", bus.out_valid); end
    n_checks++; if (bus.acc_out !== 32'h0000_0000) begin n_fail++; $display("FAIL len0_acc_out: got %h expected 00000000", bus.acc_out); end
    n_checks++; if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL len0_sat: got %b expected 0", bus.sat); end
    n_checks++; if (bus.prod_ready !== 1'b0) begin n_fail++; $display("FAIL len0_prod_ready: got %b expected 0", bus.prod_ready); end
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
  endtask

  // Result held under backpressure; start and products ignored until taken.
  task automatic test_backpressure();
    bus.start = 1'b1; bus.len = 8'd1;
    step();
    bus.start = 1'b0;
    bus.prod = 32'd5; bus.prod_valid = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      bus.start = 1'b1; bus.len = 8'd2; bus.prod = 32'd99; bus.prod_valid = 1'b1; bus.out_ready = 1'b0;
      step();
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp%0d_out_valid: got %b expected 1", c, bus.out_valid); end
      n_checks++; if (bus.acc_out !== 32'd5) begin n_fail++; $display("FAIL bp%0d_acc_out: got %h expected 00000005", c, bus.acc_out); end
      n_checks++; if (bus.prod_ready !== 1'b0) begin n_fail++; $display("FAIL bp%0d_prod_ready: got %b expected 0", c, bus.prod_ready); end
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL bp%0d_busy: got %b expected 1", c, bus.busy); end
    end
    bus.prod_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    bus.start = 1'b0; bus.out_ready = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL bp_release_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", bus.out_valid); end
    step();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL bp_start_ignored: got %b expected 0", bus.busy); end
  endtask

  // Reset mid-run discards the partial sum; a following run is clean.
  task automatic test_reset_midrun();
    bus.start = 1'b1; bus.len = 8'd3;
    step();
    bus.start = 1'b0;
    bus.prod = 32'd1000; bus.prod_valid = 1'b1;
    step();
    bus.prod_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.acc_out !== 32'h0000_0000) begin n_fail++; $display("FAIL rstmid_acc_out: got %h expected 00000000", bus.acc_out); end
    bus.start = 1'b1; bus.len = 8'd1;
    step();
    bus.start = 1'b0;
    bus.prod = 32'hFFFF_FFF7; bus.prod_valid = 1'b1;
    step();
    bus.prod_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_new_valid: got %b expected 1", bus.out_valid); end
    n_checks++; if (bus.acc_out !== 32'hFFFF_FFF7) begin n_fail++; $display("FAIL rstmid_new_acc: got %h expected fffffff7", bus.acc_out); end
    n_checks++; if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL rstmid_new_sat: got %b expected 0", bus.sat); end
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
  endtask

  // Two runs back to back with prod_valid held high; checks LEN+1 latency.
  task automatic test_back_to_back();
    logic [31:0] vals [0:1];
    int cycles;
    int k;
    vals[0] = 32'd10; vals[1] = 32'd20;
    cycles = 0; k = 0;
    bus.start = 1'b1; bus.len = 8'd2;
    step(); cycles++;
    bus.start = 1'b0; bus.prod_valid = 1'b1;
    while (!bus.out_valid && cycles < 20) begin
      bus.prod = vals[k];
      step(); cycles++;
      if (k < 1) k++;
    end
    n_checks++; if (cycles !== 3) begin n_fail++; $display("FAIL b2b_latency: got %0d cycles expected 3", cycles); end
    n_checks++; if (bus.acc_out !== 32'd30) begin n_fail++; $display("FAIL b2b_first_acc: got %h expected 0000001e", bus.acc_out); end
    bus.prod = 32'd77; bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    bus.start = 1'b1; bus.len = 8'd2;
    step();
    bus.start = 1'b0;
    bus.prod = 32'd1; step();
    bus.prod = 32'd2; step();
    bus.prod_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid: got %b expected 1", bus.out_valid); end
    n_checks++; if (bus.acc_out !== 32'd3) begin n_fail++; $display("FAIL b2b_second_acc: got %h expected 00000003", bus.acc_out); end
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.len = 8'd0; bus.prod_valid = 1'b0;
    bus.prod = 32'd0; bus.out_ready = 1'b0;
    test_reset();
    test_basic_gaps();
    test_saturation();
    test_len_zero();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
